// File: rtl/hist_pkg.sv
// Shared types and helpers for the history reader.
// Build option HIST_READER_DEDUP_EN (used in hist_snapshot) drops repeated values at capture.
package hist_pkg;

    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned HIST_IDX_W = 2;
    localparam int unsigned HIST_CNT_W = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} hist_state_t;

    typedef logic [HIST_DEPTH-1:0] hist_mask_t;

    // Highest set bit when hi=1, lowest set bit when hi=0; 0 for an empty mask.
    function automatic logic [HIST_IDX_W-1:0] hist_pick(input hist_mask_t mask, input logic hi);
        logic [HIST_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            if (hi && mask[i]) idx = HIST_IDX_W'(i);
        end
        for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
            if (!hi && mask[i]) idx = HIST_IDX_W'(i);
        end
        return idx;
    endfunction

    // Entries still to be sent after idx, walking down (hi=1) or up (hi=0).
    function automatic hist_mask_t hist_rest(input hist_mask_t mask,
                                             input logic [HIST_IDX_W-1:0] idx,
                                             input logic hi);
        hist_mask_t rest;
        for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            rest[i] = mask[i] && (hi ? (i < int'(idx)) : (i > int'(idx)));
        end
        return rest;
    endfunction

    function automatic logic [HIST_CNT_W-1:0] hist_popcount(input hist_mask_t mask);
        logic [HIST_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            cnt = cnt + {{(HIST_CNT_W-1){1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hist_reader_if.sv
// Valid/ready output stream of the history reader.
interface hist_reader_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/hist_snapshot.sv
// Capture registers for the 4-entry history plus the emit mask and entry count.
// Build option HIST_READER_DEDUP_EN: prefix entries repeating a lower-index value are skipped.
module hist_snapshot
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                              clk_in,
    input  logic                              reset_in,
    input  logic                              capture,
    input  logic [HIST_DEPTH-1:0][DATA_W-1:0] live_data,
    input  hist_mask_t                        live_valid,
    output hist_mask_t                        live_emit,
    output logic [HIST_DEPTH-1:0][DATA_W-1:0] snap_data,
    output hist_mask_t                        snap_emit,
    output logic [HIST_CNT_W-1:0]             snap_cnt
);

    hist_mask_t prefix;
    hist_mask_t skip;

    logic [HIST_DEPTH-1:0][DATA_W-1:0] snap_data_q;
    hist_mask_t                        snap_emit_q;
    logic [HIST_CNT_W-1:0]             snap_cnt_q;

    // Contiguous valid run starting at entry 0; a gap ends it.
    always_comb begin
        prefix    = '0;
        prefix[0] = live_valid[0];
        for (int i = 1; i < int'(HIST_DEPTH); i++) begin
            prefix[i] = prefix[i-1] & live_valid[i];
        end
    end

`ifdef HIST_READER_DEDUP_EN
    // Mark entries whose value already appears at a lower index.
    always_comb begin
        skip = '0;
        for (int i = 1; i < int'(HIST_DEPTH); i++) begin
            for (int j = 0; j < i; j++) begin
                if (live_data[i] == live_data[j]) skip[i] = 1'b1;
            end
        end
    end
`else
    assign skip = '0;
`endif

    assign live_emit = prefix & ~skip;

    // Freeze data, emit mask and count on a capture request.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            snap_data_q <= '0;
            snap_emit_q <= '0;
            snap_cnt_q  <= '0;
        end else if (capture) begin
            snap_data_q <= live_data;
            snap_emit_q <= live_emit;
            snap_cnt_q  <= hist_popcount(live_emit);
        end
    end

    assign snap_data = snap_data_q;
    assign snap_emit = snap_emit_q;
    assign snap_cnt  = snap_cnt_q;

endmodule

// File: rtl/hist_reader.sv
// Snapshots the recent-value history on request and streams the valid entries out.
// Build option HIST_READER_DEDUP_EN: duplicate values are dropped at capture (see hist_snapshot).
module hist_reader
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned OLDEST_FIRST = 1
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [DATA_W-1:0]     hist_data_0,
    input  logic [DATA_W-1:0]     hist_data_1,
    input  logic [DATA_W-1:0]     hist_data_2,
    input  logic [DATA_W-1:0]     hist_data_3,
    input  logic                  hist_valid_0,
    input  logic                  hist_valid_1,
    input  logic                  hist_valid_2,
    input  logic                  hist_valid_3,
    input  logic                  req_in,
    hist_reader_if.master         m_if,
    output logic                  busy,
    output logic                  done,
    output logic [HIST_CNT_W-1:0] entry_cnt
);

    localparam logic FROM_TOP = (OLDEST_FIRST != 0);

    logic [HIST_DEPTH-1:0][DATA_W-1:0] live_data;
    hist_mask_t                        live_valid;
    hist_mask_t                        live_emit;
    logic [HIST_DEPTH-1:0][DATA_W-1:0] snap_data;
    hist_mask_t                        snap_emit;
    logic [HIST_CNT_W-1:0]             snap_cnt;
    logic                              capture;
    hist_mask_t                        rest;

    hist_state_t             state_q, state_d;
    logic [HIST_IDX_W-1:0]   idx_q, idx_d;

    assign live_data  = {hist_data_3, hist_data_2, hist_data_1, hist_data_0};
    assign live_valid = {hist_valid_3, hist_valid_2, hist_valid_1, hist_valid_0};

    hist_snapshot #(
        .DATA_W (DATA_W)
    ) u_snapshot (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .capture    (capture),
        .live_data  (live_data),
        .live_valid (live_valid),
        .live_emit  (live_emit),
        .snap_data  (snap_data),
        .snap_emit  (snap_emit),
        .snap_cnt   (snap_cnt)
    );

    // State and read-index registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, index stepping and stream outputs.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        capture        = 1'b0;
        m_if.m_valid   = 1'b0;
        m_if.m_last    = 1'b0;
        m_if.m_data    = '0;
        done           = 1'b0;
        // Entries left after the current one; empty means this is the final beat.
        rest           = hist_rest(snap_emit, idx_q, FROM_TOP);

        unique case (state_q)
            ST_IDLE: begin
                if (req_in) begin
                    capture = 1'b1;
                    if (live_emit == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                        idx_d   = hist_pick(live_emit, FROM_TOP);
                    end
                end
            end
            ST_SEND: begin
                m_if.m_valid = 1'b1;
                m_if.m_data  = snap_data[idx_q];
                m_if.m_last  = (rest == '0);
                if (m_if.m_ready) begin
                    if (rest == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = hist_pick(rest, FROM_TOP);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign entry_cnt = snap_cnt;

endmodule

// File: tb/tb_hist_reader.sv
// Directed bench for hist_reader: one instance per emit order, shared stimulus.
module tb_hist_reader;
    import hist_pkg::*;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic [3:0][7:0]  hist_data;
    logic [3:0]       hist_valid;
    logic             req_in;
    logic             m_ready;
    logic             sel_nf;

    logic             busy_of, done_of, busy_nf, done_nf;
    logic [2:0]       cnt_of, cnt_nf;

    logic [7:0]       obs_data;
    logic             obs_valid, obs_last, obs_busy, obs_done;
    logic [2:0]       obs_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    hist_reader_if #(.DATA_W(8)) if_of ();
    hist_reader_if #(.DATA_W(8)) if_nf ();

    assign if_of.m_ready = m_ready;
    assign if_nf.m_ready = m_ready;

    hist_reader #(.DATA_W(8), .OLDEST_FIRST(1)) dut_of (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .hist_data_0  (hist_data[0]),
        .hist_data_1  (hist_data[1]),
        .hist_data_2  (hist_data[2]),
        .hist_data_3  (hist_data[3]),
        .hist_valid_0 (hist_valid[0]),
        .hist_valid_1 (hist_valid[1]),
        .hist_valid_2 (hist_valid[2]),
        .hist_valid_3 (hist_valid[3]),
        .req_in       (req_in),
        .m_if         (if_of.master),
        .busy         (busy_of),
        .done         (done_of),
        .entry_cnt    (cnt_of)
    );

    hist_reader #(.DATA_W(8), .OLDEST_FIRST(0)) dut_nf (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .hist_data_0  (hist_data[0]),
        .hist_data_1  (hist_data[1]),
        .hist_data_2  (hist_data[2]),
        .hist_data_3  (hist_data[3]),
        .hist_valid_0 (hist_valid[0]),
        .hist_valid_1 (hist_valid[1]),
        .hist_valid_2 (hist_valid[2]),
        .hist_valid_3 (hist_valid[3]),
        .req_in       (req_in),
        .m_if         (if_nf.master),
        .busy         (busy_nf),
        .done         (done_nf),
        .entry_cnt    (cnt_nf)
    );

    always_comb begin
        obs_data  = sel_nf ? if_nf.m_data  : if_of.m_data;
        obs_valid = sel_nf ? if_nf.m_valid : if_of.m_valid;
        obs_last  = sel_nf ? if_nf.m_last  : if_of.m_last;
        obs_busy  = sel_nf ? busy_nf       : busy_of;
        obs_done  = sel_nf ? done_nf       : done_of;
        obs_cnt   = sel_nf ? cnt_nf        : cnt_of;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Beat list in emission order: b0 goes out first.
    function automatic logic [3:0][7:0] beats4(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    // Request with m_ready high; check every beat, the done cycle and the return to idle.
    task automatic run_xfer(input logic nf, input string name, input int n,
                            input logic [3:0][7:0] exp, input int cnt);
        sel_nf  = nf;
        m_ready = 1'b1;
        req_in  = 1'b1;
        tick();
        req_in    = 1'b0;
        hist_data = {4{8'hEE}};  // live changes must not reach the snapshot
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s beat%0d valid", name, i), 32'(obs_valid), 32'd1);
            check($sformatf("%s beat%0d data", name, i), 32'(obs_data), 32'(exp[i]));
            check($sformatf("%s beat%0d last", name, i), 32'(obs_last), 32'(i == n - 1));
            check($sformatf("%s beat%0d busy", name, i), 32'(obs_busy), 32'd1);
            check($sformatf("%s beat%0d done", name, i), 32'(obs_done), 32'd0);
            if (i == 0) check($sformatf("%s cnt", name), 32'(obs_cnt), 32'(cnt));
            tick();
        end
        check($sformatf("%s done", name), 32'(obs_done), 32'd1);
        check($sformatf("%s done busy", name), 32'(obs_busy), 32'd1);
        check($sformatf("%s done valid", name), 32'(obs_valid), 32'd0);
        tick();
        check($sformatf("%s idle done", name), 32'(obs_done), 32'd0);
        check($sformatf("%s idle busy", name), 32'(obs_busy), 32'd0);
        check($sformatf("%s idle cnt", name), 32'(obs_cnt), 32'(cnt));
        tick();
    endtask

    initial begin
        logic [4:0] rdy_seq;
        logic [4:0] last_seq;
        logic [4:0][7:0] data_seq;

        reset_in   = 1'b1;
        req_in     = 1'b0;
        m_ready    = 1'b1;
        sel_nf     = 1'b0;
        hist_data  = '0;
        hist_valid = '0;
        tick();
        tick();
        check("rst m_data", 32'(if_of.m_data), 32'd0);
        check("rst m_valid", 32'(if_of.m_valid), 32'd0);
        check("rst m_last", 32'(if_of.m_last), 32'd0);
        check("rst busy", 32'(busy_of), 32'd0);
        check("rst done", 32'(done_of), 32'd0);
        check("rst cnt", 32'(cnt_of), 32'd0);
        check("rst nf valid", 32'(if_nf.m_valid), 32'd0);
        reset_in = 1'b0;
        tick();

        // Full history, both emit orders.
        hist_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        hist_valid = 4'b1111;
        run_xfer(1'b0, "full_of", 4, beats4(8'h44, 8'h33, 8'h22, 8'h11), 4);
        hist_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        run_xfer(1'b1, "full_nf", 4, beats4(8'h11, 8'h22, 8'h33, 8'h44), 4);

        // Gap at index 1 truncates the prefix to one entry.
        hist_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        hist_valid = 4'b1101;
        run_xfer(1'b0, "gap", 1, beats4(8'hAA, 8'h00, 8'h00, 8'h00), 1);

        // Backpressure on a 2-entry transfer.
        hist_data  = {8'h00, 8'h00, 8'h06, 8'h05};
        hist_valid = 4'b0011;
        rdy_seq    = 5'b10100;  // cycle c uses bit c: 0,0,1,0,1
        last_seq   = 5'b11000;
        data_seq   = {8'h05, 8'h05, 8'h06, 8'h06, 8'h06};
        sel_nf     = 1'b0;
        m_ready    = 1'b0;
        req_in     = 1'b1;
        tick();
        req_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            m_ready = rdy_seq[c];
            check($sformatf("bp c%0d valid", c), 32'(obs_valid), 32'd1);
            check($sformatf("bp c%0d data", c), 32'(obs_data), 32'(data_seq[c]));
            check($sformatf("bp c%0d last", c), 32'(obs_last), 32'(last_seq[c]));
            check($sformatf("bp c%0d done", c), 32'(obs_done), 32'd0);
            tick();
        end
        m_ready = 1'b1;
        check("bp done", 32'(obs_done), 32'd1);
        check("bp done valid", 32'(obs_valid), 32'd0);
        tick();
        check("bp no second done", 32'(obs_done), 32'd0);
        check("bp idle busy", 32'(obs_busy), 32'd0);
        check("bp cnt", 32'(obs_cnt), 32'd2);
        tick();

        // Empty history; req held into the done cycle must be ignored.
        hist_valid = 4'b0000;
        req_in     = 1'b1;
        tick();
        check("empty done", 32'(obs_done), 32'd1);
        check("empty busy", 32'(obs_busy), 32'd1);
        check("empty valid", 32'(obs_valid), 32'd0);
        check("empty cnt", 32'(obs_cnt), 32'd0);
        tick();
        req_in = 1'b0;
        check("empty req ignored busy", 32'(obs_busy), 32'd0);
        check("empty req ignored done", 32'(obs_done), 32'd0);
        check("empty req ignored valid", 32'(obs_valid), 32'd0);
        tick();

        // A req pulse mid-transfer is not queued.
        hist_data  = {8'h00, 8'h33, 8'h32, 8'h31};
        hist_valid = 4'b0111;
        req_in     = 1'b1;
        tick();
        req_in = 1'b0;
        check("busyreq b0", 32'(obs_data), 32'h33);
        tick();
        req_in = 1'b1;
        check("busyreq b1", 32'(obs_data), 32'h32);
        tick();
        req_in = 1'b0;
        check("busyreq b2", 32'(obs_data), 32'h31);
        check("busyreq b2 last", 32'(obs_last), 32'd1);
        tick();
        check("busyreq done", 32'(obs_done), 32'd1);
        tick();
        check("busyreq idle", 32'(obs_busy), 32'd0);
        tick();
        check("busyreq no restart", 32'(obs_busy), 32'd0);
        check("busyreq no valid", 32'(obs_valid), 32'd0);

        // Asynchronous reset after the first of four beats.
        hist_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        hist_valid = 4'b1111;
        req_in     = 1'b1;
        tick();
        req_in = 1'b0;
        check("arst b0", 32'(obs_data), 32'h44);
        tick();
        check("arst b1", 32'(obs_data), 32'h33);
        #2;
        reset_in = 1'b1;
        #1;
        check("arst valid", 32'(obs_valid), 32'd0);
        check("arst busy", 32'(obs_busy), 32'd0);
        check("arst cnt", 32'(obs_cnt), 32'd0);
        check("arst data", 32'(obs_data), 32'd0);
        tick();
        check("arst no done", 32'(obs_done), 32'd0);
        reset_in = 1'b0;
        tick();
        check("arst post done", 32'(obs_done), 32'd0);
        check("arst post busy", 32'(obs_busy), 32'd0);
        hist_data = {8'h44, 8'h33, 8'h22, 8'h11};
        run_xfer(1'b0, "arst restart", 4, beats4(8'h44, 8'h33, 8'h22, 8'h11), 4);

        // Repeated values, newest-first order.
        hist_data  = {8'h09, 8'h07, 8'h09, 8'h07};
        hist_valid = 4'b1111;
`ifdef HIST_READER_DEDUP_EN
        run_xfer(1'b1, "dedup", 2, beats4(8'h07, 8'h09, 8'h00, 8'h00), 2);
`else
        run_xfer(1'b1, "dup", 4, beats4(8'h07, 8'h09, 8'h07, 8'h09), 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
